// File: rtl/pe_output_drain.sv
// Drains partial sums from a group of output PEs, block by block, after a tile completes.
// Each PE is read with a one-cycle strobe, and its sum is presented on a valid/ready stream.
module pe_output_drain #(
    parameter int O_PEGroupSize   = 4,
    parameter int O_PEAddrWidth   = 2,
    parameter int DataWidth       = 16,
    parameter int BlockCount      = 4,
    parameter int BlockCountWidth = 3,
    parameter int ReadLatency     = 1
) (
    input  logic                       clk,
    input  logic                       sclr,
    input  logic                       clk_en,
    input  logic                       start,
    output logic [O_PEAddrWidth-1:0]   O_Out_PEAddr,
    output logic                       O_RD_EN,
    input  logic [DataWidth-1:0]       PE_Data,
    output logic [DataWidth-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [BlockCountWidth-1:0] block_idx,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [O_PEAddrWidth-1:0]   LastAddr  = O_PEAddrWidth'(O_PEGroupSize - 1);
    localparam logic [BlockCountWidth-1:0] LastBlock = BlockCountWidth'(BlockCount - 1);
    // Counts down to zero; the capture happens on the zero cycle, so load ReadLatency-1.
    localparam logic [2:0]                 LatLoad   = 3'(ReadLatency - 1);

    state_t     state_r;
    logic [2:0] lat_cnt_r;

    // Drain sequencer: all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_r      <= S_IDLE;
            lat_cnt_r    <= 3'd0;
            O_Out_PEAddr <= '0;
            O_RD_EN      <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            block_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (clk_en) begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r      <= S_READ;
                        O_RD_EN      <= 1'b1;
                        busy         <= 1'b1;
                        O_Out_PEAddr <= '0;
                        block_idx    <= '0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_READ: begin
                    O_RD_EN   <= 1'b0;
                    lat_cnt_r <= LatLoad;
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt_r == 3'd0) begin
                        out_data  <= PE_Data;
                        out_valid <= 1'b1;
                        out_last  <= (O_Out_PEAddr == LastAddr);
                        state_r   <= S_HOLD;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (O_Out_PEAddr == LastAddr) begin
                            O_Out_PEAddr <= '0;
                            if (block_idx == LastBlock) begin
                                state_r <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                block_idx <= block_idx + 1'b1;
                                state_r   <= S_READ;
                                O_RD_EN   <= 1'b1;
                            end
                        end else begin
                            O_Out_PEAddr <= O_Out_PEAddr + 1'b1;
                            state_r      <= S_READ;
                            O_RD_EN      <= 1'b1;
                        end
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                S_DONE: begin
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    O_Out_PEAddr <= '0;
                    block_idx    <= '0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    state_r      <= S_IDLE;
                    O_RD_EN      <= 1'b0;
                    out_valid    <= 1'b0;
                    out_last     <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    O_Out_PEAddr <= '0;
                    block_idx    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_output_drain.sv
// Scoreboard bench for pe_output_drain: a ReadLatency=1 instance for drain/backpressure/abort
// scenarios and a ReadLatency=3 instance for clock-enable freezes mid-wait.
module tb_pe_output_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sclr = 1'b1, clk_en = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [1:0]  addr;
    logic        rd_en, out_valid, out_last, busy, done;
    logic [15:0] pe_data = 16'h0000, out_data;
    logic [2:0]  blk;

    logic        ce3 = 1'b1, start3 = 1'b0, ready3 = 1'b0;
    logic [1:0]  addr3;
    logic        rd3, valid3, last3, busy3, done3;
    logic [15:0] pe3, data3;
    logic [15:0] p3 [3];
    logic [2:0]  blk3;

    pe_output_drain #(.ReadLatency(1)) dut (
        .clk(clk), .sclr(sclr), .clk_en(clk_en), .start(start),
        .O_Out_PEAddr(addr), .O_RD_EN(rd_en), .PE_Data(pe_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .block_idx(blk), .busy(busy), .done(done)
    );

    pe_output_drain #(.ReadLatency(3)) dut3 (
        .clk(clk), .sclr(sclr), .clk_en(ce3), .start(start3),
        .O_Out_PEAddr(addr3), .O_RD_EN(rd3), .PE_Data(pe3),
        .out_data(data3), .out_valid(valid3), .out_ready(ready3), .out_last(last3),
        .block_idx(blk3), .busy(busy3), .done(done3)
    );

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pe_val(input logic [1:0] a, input logic [2:0] b);
        return 16'h0100 + 16'(b) * 16'd16 + 16'(a);
    endfunction

    function automatic logic [15:0] exp_word(input int k);
        return 16'h0100 + 16'(16 * (k / 4)) + 16'(k % 4);
    endfunction

    // PE array models: return the sum ReadLatency enabled cycles after the strobe
    always @(posedge clk) begin
        if (clk_en) pe_data <= rd_en ? pe_val(addr, blk) : 16'hDEAD;
    end
    always @(posedge clk) begin
        if (ce3) begin
            p3[0] <= rd3 ? pe_val(addr3, blk3) : 16'hDEAD;
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign pe3 = p3[2];

    // Scoreboard for the ReadLatency=1 instance
    int exp_k = 0, rd_cnt = 0, acc_cnt = 0, done_cnt = 0, cyc = 0, last_acc = 0, mon_k;
    int sb_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!sclr && clk_en) begin
            if (rd_en) begin
                chk("rd_addr", 32'(addr), 32'(exp_k % 4));
                chk("rd_block", 32'(blk), 32'(exp_k / 4));
                sb_q.push_back(exp_k);
                exp_k++;
                rd_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    mon_k = sb_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(exp_word(mon_k)));
                    chk("word_last", 32'(out_last), 32'(mon_k % 4 == 3));
                end
                acc_cnt++;
                last_acc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_words", 32'(acc_cnt), 32'd16);
                chk("done_gap", 32'(cyc - last_acc), 32'd1);
            end
        end
    end

    task automatic clear_sb();
        exp_k = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0;
        sb_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_drain(input bit stall, input bit poke);
        int  n;
        int  cnt;
        bit  stalled;
        bit  poked;
        stalled = 1'b0;
        poked   = 1'b0;
        clear_sb();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'd3);
        cnt = 0;
        while (done_cnt == 0 && cnt < 400) begin
            if (stall && !stalled && acc_cnt == 2) begin
                out_ready = 1'b0;
                n = 0;
                while (!out_valid && n < 20) begin
                    step();
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    chk("stall_data", 32'(out_data), 32'h0102);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_no_rd", 32'(rd_en), 32'd0);
                    step();
                end
                out_ready = 1'b1;
                stalled = 1'b1;
            end else if (poke && !poked && acc_cnt == 5) begin
                start = 1'b1;
                step();
                start = 1'b0;
                poked = 1'b1;
            end else begin
                step();
            end
            cnt++;
        end
        if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
        repeat (3) step();
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("words_accepted", 32'(acc_cnt), 32'd16);
        chk("reads_issued", 32'(rd_cnt), 32'd16);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        // Reset state
        sclr = 1'b1;
        repeat (3) step();
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_block", 32'(blk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        sclr = 1'b0;
        step();

        // sclr for 2 cycles while a word is held
        clear_sb();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("hold_reached", 32'(out_valid), 32'd1);
        sclr = 1'b1;
        repeat (2) step();
        sclr = 1'b0;
        chk("hold_rst_valid", 32'(out_valid), 32'd0);
        chk("hold_rst_data", 32'(out_data), 32'd0);
        chk("hold_rst_busy", 32'(busy), 32'd0);
        chk("hold_rst_addr", 32'(addr), 32'd0);
        chk("hold_rst_rd", 32'(rd_en), 32'd0);
        step();
        run_drain(1'b0, 1'b0);

        // Backpressure on word 2
        run_drain(1'b1, 1'b0);

        // start while busy is ignored, then a fresh drain after done
        run_drain(1'b0, 1'b1);
        run_drain(1'b0, 1'b0);

        // Abort in block 2 WAIT
        clear_sb();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (rd_cnt < 9 && n < 200) begin
            step();
            n++;
        end
        chk("abort_reached_blk2", 32'(blk), 32'd2);
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_block", 32'(blk), 32'd0);
        repeat (4) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        run_drain(1'b0, 1'b0);

        // ReadLatency=3 with a clk_en freeze mid-WAIT
        ready3 = 1'b0;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        n = 1;
        step();
        n++;
        chk("rl3_busy", 32'(busy3), 32'd1);
        ce3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rl3_frozen_valid", 32'(valid3), 32'd0);
            chk("rl3_frozen_rd", 32'(rd3), 32'd0);
        end
        ce3 = 1'b1;
        while (!valid3 && n < 20) begin
            step();
            n++;
        end
        chk("rl3_latency", 32'(n), 32'd5);
        chk("rl3_word0", 32'(data3), 32'h0100);
        chk("rl3_last0", 32'(last3), 32'd0);
        ready3 = 1'b1;
        step();
        ready3 = 1'b0;
        n = 0;
        while (!valid3 && n < 20) begin
            step();
            n++;
        end
        chk("rl3_word1", 32'(data3), 32'h0101);
        chk("rl3_addr1", 32'(addr3), 32'd1);
        // Handshake with clk_en low must not count as an accept
        ready3 = 1'b1;
        ce3 = 1'b0;
        repeat (2) step();
        chk("rl3_ce_hold_valid", 32'(valid3), 32'd1);
        chk("rl3_ce_hold_addr", 32'(addr3), 32'd1);
        ce3 = 1'b1;
        step();
        chk("rl3_accepted", 32'(valid3), 32'd0);
        ready3 = 1'b0;
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        chk("rl3_rst_busy", 32'(busy3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
